// File: rtl/io_int_ctrl.sv
// Edge-latching, maskable, fixed-priority interrupt controller with req/ack/eoi handshake to the CPU.
// Source edge to irq is 2 cycles; one interrupt is in flight at a time, new edges stay pending meanwhile.
module io_int_ctrl #(
    parameter int               ID_W       = 2,
    parameter int               VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int               VEC_STRIDE = 4,
    localparam int              NSRC       = 2**ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  src_in,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_din,
    output logic [NSRC-1:0]  mask_q,
    output logic [NSRC-1:0]  pending_q,
    output logic             irq,
    input  logic             ack,
    input  logic             eoi,
    output logic [VEC_W-1:0] vector,
    output logic [ID_W-1:0]  active_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NSRC-1:0]   r_prev;
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   r_mask;
    logic              r_irq;
    logic [VEC_W-1:0]  r_vector;
    logic [ID_W-1:0]   r_active_id;

    logic [NSRC-1:0]   w_eligible;
    logic [NSRC-1:0]   w_rise;
    logic [NSRC-1:0]   w_clr;
    logic [ID_W-1:0]   w_winner;
    logic [VEC_W-1:0]  w_vec;
    logic              w_load;
    logic              w_take;

    assign w_eligible = r_pending & r_mask;
    assign w_rise     = src_in & ~r_prev;
    assign w_take     = (r_state == ST_REQ) && ack;
    assign w_clr      = w_take ? (NSRC'(1) << r_active_id) : '0;
    assign w_vec      = VEC_BASE + VEC_W'(w_winner) * VEC_W'(VEC_STRIDE);

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_winner = ID_W'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt = ST_REQ;
                    w_load      = 1'b1;
                end
            end
            ST_REQ: begin
                // ack beats a coincident mask clear of the selected source
                if (ack)                        w_state_nxt = ST_SVC;
                else if (!r_mask[r_active_id])  w_state_nxt = ST_IDLE;
            end
            ST_SVC: begin
                if (eoi) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_pending   <= '0;
            r_mask      <= '0;
            r_irq       <= 1'b0;
            r_vector    <= '0;
            r_active_id <= '0;
        end else begin
            r_prev    <= src_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_irq     <= (w_state_nxt == ST_REQ);
            if (mask_we) r_mask <= mask_din;
            if (w_load) begin
                r_vector    <= w_vec;
                r_active_id <= w_winner;
            end
        end
    end

    assign mask_q    = r_mask;
    assign pending_q = r_pending;
    assign irq       = r_irq;
    assign vector    = r_vector;
    assign active_id = r_active_id;

endmodule

// File: tb/tb_io_int_ctrl.sv
// Directed bench for io_int_ctrl: a cycle-level reference model is compared on every falling edge,
// and literal expectations taken from the interrupt timing rules pin the model itself.
module tb_io_int_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] src_in = '0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_din = '0;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic       irq;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic [9:0] vector;
    logic [1:0] active_id;

    int checks = 0;
    int errors = 0;

    io_int_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .src_in    (src_in),
        .mask_we   (mask_we),
        .mask_din  (mask_din),
        .mask_q    (mask_q),
        .pending_q (pending_q),
        .irq       (irq),
        .ack       (ack),
        .eoi       (eoi),
        .vector    (vector),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy says whether an interrupt is owned (requested or in service).
    bit       m_busy, m_acked;
    int       m_id;
    bit [3:0] m_prev, m_pend, m_mask;
    bit [9:0] m_vec;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_acked = 0; m_id = 0; m_vec = '0;
            m_prev = '0; m_pend = '0; m_mask = '0;
        end else begin
            bit [3:0] elig;
            bit [3:0] edges;
            elig  = m_pend & m_mask;
            edges = src_in & ~m_prev;
            if (!m_busy) begin
                for (int i = 0; i < 4; i++) begin
                    if (elig[i] && !m_busy) begin
                        m_busy = 1; m_acked = 0; m_id = i;
                        m_vec = 10'(960 + 4 * i);
                    end
                end
            end else if (!m_acked) begin
                if (ack) begin
                    m_acked = 1;
                    m_pend[m_id] = 1'b0;
                end else if (!m_mask[m_id]) begin
                    m_busy = 0;
                end
            end else if (eoi) begin
                m_busy = 0; m_acked = 0;
            end
            m_pend = m_pend | edges;
            if (mask_we) m_mask = mask_din;
            m_prev = src_in;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("cmp_irq",       32'(irq),       32'(m_busy && !m_acked));
            chk("cmp_pending",   32'(pending_q), 32'(m_pend));
            chk("cmp_mask",      32'(mask_q),    32'(m_mask));
            chk("cmp_active_id", 32'(active_id), 32'(m_id));
            chk("cmp_vector",    32'(vector),    32'(m_vec));
        end
    end

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_din = m;
        cyc();
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; cyc(); ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1; cyc(); eoi = 1'b0;
    endtask

    initial begin
        @(negedge clk); #1;
        cyc(2);
        chk("rst_irq",     32'(irq),       32'h0);
        chk("rst_pending", 32'(pending_q), 32'h0);
        chk("rst_vector",  32'(vector),    32'h0);
        reset = 1'b1;
        cyc();

        // single source, basic handshake
        write_mask(4'b1111);
        chk("a_mask", 32'(mask_q), 32'hF);
        src_in = 4'b0100; cyc(); src_in = '0;
        chk("a_pend", 32'(pending_q), 32'h4);
        chk("a_irq0", 32'(irq), 32'h0);
        cyc();
        chk("a_irq1", 32'(irq), 32'h1);
        chk("a_id",   32'(active_id), 32'h2);
        chk("a_vec",  32'(vector), 32'h3C8);
        cyc();
        pulse_ack();
        chk("a_ack_irq",  32'(irq), 32'h0);
        chk("a_ack_pend", 32'(pending_q), 32'h0);
        cyc();
        pulse_eoi();
        cyc(2);
        chk("a_idle_irq", 32'(irq), 32'h0);

        // two simultaneous sources: lower index first
        src_in = 4'b1010; cyc(); src_in = '0;
        cyc();
        chk("b_id1",  32'(active_id), 32'h1);
        chk("b_vec1", 32'(vector), 32'h3C4);
        pulse_ack();
        pulse_eoi();
        chk("b_gap_irq", 32'(irq), 32'h0);
        cyc();
        chk("b_irq3", 32'(irq), 32'h1);
        chk("b_id3",  32'(active_id), 32'h3);
        chk("b_vec3", 32'(vector), 32'h3CC);
        pulse_ack();
        pulse_eoi();

        // masked edge latches, unmasking raises irq
        write_mask(4'b0000);
        src_in = 4'b0001; cyc(); src_in = '0;
        chk("c_pend", 32'(pending_q), 32'h1);
        cyc();
        chk("c_irq_masked", 32'(irq), 32'h0);
        write_mask(4'b0001);
        chk("c_irq_w", 32'(irq), 32'h0);
        cyc();
        chk("c_irq_on", 32'(irq), 32'h1);
        chk("c_vec",    32'(vector), 32'h3C0);
        pulse_ack();
        pulse_eoi();

        // withdraw by masking the requested source
        write_mask(4'b1111);
        src_in = 4'b0010; cyc(); src_in = '0;
        cyc();
        chk("d_irq", 32'(irq), 32'h1);
        write_mask(4'b1101);
        chk("d_irq_still", 32'(irq), 32'h1);
        cyc();
        chk("d_withdrawn", 32'(irq), 32'h0);
        chk("d_pend_kept", 32'(pending_q), 32'h2);
        write_mask(4'b1111);
        cyc();
        chk("d_rereq", 32'(irq), 32'h1);
        // ack coinciding with a fresh edge on the same source keeps it pending
        ack = 1'b1; src_in = 4'b0010; cyc(); ack = 1'b0; src_in = '0;
        chk("d_setwins_irq",  32'(irq), 32'h0);
        chk("d_setwins_pend", 32'(pending_q), 32'h2);
        pulse_eoi();
        cyc();
        pulse_ack();
        pulse_eoi();

        // stray ack/eoi, and a level held high
        pulse_ack();
        chk("e_stray_ack", 32'(irq), 32'h0);
        src_in = 4'b0001;
        cyc(2);
        chk("e_lvl_irq", 32'(irq), 32'h1);
        pulse_eoi();
        chk("e_stray_eoi", 32'(irq), 32'h1);
        pulse_ack();
        pulse_eoi();
        cyc(4);
        chk("e_once_irq",  32'(irq), 32'h0);
        chk("e_once_pend", 32'(pending_q), 32'h0);
        src_in = '0;
        cyc();

        // asynchronous reset in the middle of SERVICE
        src_in = 4'b0100; cyc(); src_in = '0;
        cyc();
        pulse_ack();
        chk("f_svc_id", 32'(active_id), 32'h2);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("f_async_irq",  32'(irq),       32'h0);
        chk("f_async_vec",  32'(vector),    32'h0);
        chk("f_async_id",   32'(active_id), 32'h0);
        chk("f_async_mask", 32'(mask_q),    32'h0);
        chk("f_async_pend", 32'(pending_q), 32'h0);
        @(negedge clk); #1;
        reset = 1'b1;
        cyc(3);
        chk("f_post_irq",  32'(irq), 32'h0);
        chk("f_post_pend", 32'(pending_q), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_int_ctrl.md
# io_int_ctrl

Interrupt controller that sequences the single-cycle CPU's response to its input/output peripherals. It latches rising edges on NSRC interrupt lines, applies a CPU-writable mask, and picks one source by fixed priority. It then drives a request/acknowledge/end-of-interrupt handshake with the CPU control unit and presents the handler's instruction-memory address. It sits between the I/O peripherals and the CPU's PC-select logic, and services one interrupt at a time (no nesting).

## Interface
- ID_W, 2, source index width; NSRC = 2**ID_W sources.
- VEC_W, 10, width of the vector (instruction address) output.
- VEC_BASE, 10'h3C0, address of source 0's handler.
- VEC_STRIDE, 4, address distance between consecutive handlers.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low: reset=0 clears all state immediately.
- src_in  in  NSRC  interrupt lines, already synchronous to clk.
- mask_we  in  1  CPU write strobe for the mask register.
- mask_din  in  NSRC  new mask value; bit=1 enables that source.
- mask_q  out  NSRC  current mask register.
- pending_q  out  NSRC  latched-edge register.
- irq  out  1  interrupt request to the CPU, registered.
- ack  in  1  one-cycle CPU acceptance pulse; the CPU jumps to vector.
- eoi  in  1  one-cycle end-of-interrupt pulse (return from handler).
- vector  out  VEC_W  handler address of the selected source.
- active_id  out  ID_W  index of the selected/serviced source.

## Operation
- Edge detect: register prev <= src_in. pending[i] is set when src_in[i]=1 and prev[i]=0. Edges latch regardless of mask.
- Eligible = pending_q & mask_q, both registered values. Priority: lowest index wins.
- Mask: mask_q <= mask_din on mask_we. The new mask affects arbitration from the next cycle.
- States:
  - IDLE: if eligible != 0, latch active_id = winner and vector = VEC_BASE + winner*VEC_STRIDE (truncated to VEC_W), then go to REQ.
  - REQ: irq=1, and active_id/vector are frozen (no re-arbitration, even if a higher-priority source appears).
    - On ack: clear pending[active_id] and go to SERVICE.
    - If mask_q[active_id]=0 (source masked after selection) and ack=0: withdraw, go to IDLE with pending kept. If ack and the mask clear coincide, ack wins.
  - SERVICE: irq=0; active_id/vector hold. On eoi, go to IDLE.
- Ignored inputs: ack outside REQ; eoi outside SERVICE.
- Set-wins: a new edge on a source in the same cycle its pending bit is cleared by ack leaves that bit set.
- Reset (async, any state, including mid-REQ or mid-SERVICE): state=IDLE. irq, vector, active_id, pending_q, mask_q and prev all go to 0.
  - Because prev resets to 0, a line held high through reset release registers one edge on the first clock.

## Timing
- Edge sampled at clock N: pending_q bit visible after N.
- If that source is enabled and the block is IDLE: state=REQ and irq=1 after N+1. Source-to-irq latency is 2 cycles.
- ack sampled at M: irq=0 and pending bit cleared after M.
- eoi sampled at P: IDLE after P. The next irq is earliest after P+1.
- Withdraw: mask cleared at Q makes mask_q=0 after Q, and irq=0 after Q+1.
- vector/active_id are stable from the cycle irq rises until the next IDLE→REQ transition.

## Test plan
- Reset=0 asserted mid-SERVICE, mid-cycle -> all outputs 0 immediately, without waiting for clk. Release with src_in=0000 -> stays IDLE, irq=0.
- mask=1111; pulse src_in[2] at clock 5 -> pending_q=0100 after 5; irq=1, active_id=2, vector=10'h3C8 after 6. ack at 8 -> irq=0, pending_q=0000. eoi at 10 -> IDLE.
- mask=1111; src_in[3] and src_in[1] rise together -> active_id=1, vector=10'h3C4. After ack+eoi, the next request has active_id=3, vector=10'h3CC.
- mask=0000; edge on src_in[0] -> pending_q=0001 and irq stays 0. Write mask=0001 -> irq=1 two cycles after the write clock.
- In REQ for source 1, write mask=1101 with no ack -> irq drops, IDLE, pending_q[1]=1 retained. Separately, ack in the same cycle as a new src_in[1] edge -> pending_q[1] stays 1.
- ack pulsed in IDLE and eoi pulsed in REQ -> no state change. Hold src_in[0] high continuously -> exactly one pending/irq event.
